// File: rtl/kj_calculator.sv
// Golomb parameter (kj) estimator: running error accumulator and sample count per block, one kj per non-first sample.
// Optional KJ_CALCULATOR_LAST_EN adds a kj_last output flagging the kj of the final sample in a block.
module kj_calculator #(
    parameter int MAPPED_ERROR_WIDTH = 19,
    parameter int ACC_LOG            = 5,
    parameter int BLOCK_SIZE_LOG     = 8,
    parameter int RESCALE_LOG        = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAPPED_ERROR_WIDTH-1:0] ehat_data,
    input  logic                          ehat_valid,
    output logic                          ehat_ready,
    output logic [ACC_LOG-1:0]            kj_data,
    output logic                          kj_valid,
    input  logic                          kj_ready
`ifdef KJ_CALCULATOR_LAST_EN
    ,
    output logic                          kj_last
`endif
);

    localparam int ACC_W = MAPPED_ERROR_WIDTH + RESCALE_LOG + 1;
    localparam int CNT_W = RESCALE_LOG + 1;
    localparam int CMP_W = ACC_W + ACC_LOG;
    localparam int K_NUM = 2 ** ACC_LOG;

    localparam logic [CNT_W-1:0]          RESCALE_CNT = CNT_W'(1) << RESCALE_LOG;
    localparam logic [BLOCK_SIZE_LOG-1:0] LAST_IDX    = '1;

    localparam logic [0:0] BLOCK_START = 1'b0;
    localparam logic [0:0] IN_BLOCK    = 1'b1;

    logic [0:0]                state;
    logic [BLOCK_SIZE_LOG-1:0] idx;
    logic [ACC_W-1:0]          acc;
    logic [ACC_W-1:0]          acc_sum;
    logic [ACC_W-1:0]          acc_next;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_inc;
    logic [CNT_W-1:0]          cnt_next;
    logic [ACC_LOG-1:0]        kj_calc;
    logic                      found;
    logic                      xfer;
    logic                      produce;

    assign ehat_ready = !rst && (!kj_valid || kj_ready);
    assign xfer       = ehat_valid && ehat_ready;
    assign produce    = xfer && (state == IN_BLOCK);

    // Smallest k with (cnt << k) >= acc; saturates to all-ones when none qualifies.
    always_comb begin
        kj_calc = '1;
        found   = 1'b0;
        for (int unsigned k = 0; k < K_NUM; k++) begin
            if (!found && ((CMP_W'(cnt) << k) >= CMP_W'(acc))) begin
                kj_calc = ACC_LOG'(k);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        acc_sum = acc + ACC_W'(ehat_data);
        cnt_inc = cnt + CNT_W'(1);
        if (cnt_inc == RESCALE_CNT) begin
            acc_next = acc_sum >> 1;
            cnt_next = cnt_inc >> 1;
        end else begin
            acc_next = acc_sum;
            cnt_next = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BLOCK_START;
            idx      <= '0;
            acc      <= '0;
            cnt      <= '0;
            kj_data  <= '0;
            kj_valid <= 1'b0;
        end else begin
            if (produce) begin
                kj_data  <= kj_calc;
                kj_valid <= 1'b1;
            end else if (kj_ready) begin
                kj_valid <= 1'b0;
            end

            if (xfer) begin
                idx <= idx + BLOCK_SIZE_LOG'(1);
                case (state)
                    BLOCK_START: begin
                        acc   <= ACC_W'(ehat_data);
                        cnt   <= CNT_W'(1);
                        state <= IN_BLOCK;
                    end
                    default: begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        if (idx == LAST_IDX) begin
                            state <= BLOCK_START;
                        end
                    end
                endcase
            end
        end
    end

`ifdef KJ_CALCULATOR_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            kj_last <= 1'b0;
        end else if (produce) begin
            kj_last <= (idx == LAST_IDX);
        end
    end
`else
    // Without kj_last, block boundaries are implied by the count of kj values (N-1 per block).
`endif

endmodule

// File: tb/tb_kj_calculator.sv
// Self-checking bench for kj_calculator: directed vector table on three parameterisations plus a randomized scoreboard.
module tb_kj_calculator;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] ehat_data  [3];
    logic        ehat_valid [3];
    logic        ehat_ready [3];
    logic [4:0]  kj_data    [3];
    logic        kj_valid   [3];
    logic        kj_ready   [3];
`ifdef KJ_CALCULATOR_LAST_EN
    logic        kj_last    [3];
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kj_calculator #(.BLOCK_SIZE_LOG(2), .RESCALE_LOG(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .ehat_data(ehat_data[0]), .ehat_valid(ehat_valid[0]), .ehat_ready(ehat_ready[0]),
        .kj_data(kj_data[0]), .kj_valid(kj_valid[0]), .kj_ready(kj_ready[0])
`ifdef KJ_CALCULATOR_LAST_EN
        , .kj_last(kj_last[0])
`endif
    );

    kj_calculator #(.BLOCK_SIZE_LOG(3), .RESCALE_LOG(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .ehat_data(ehat_data[1]), .ehat_valid(ehat_valid[1]), .ehat_ready(ehat_ready[1]),
        .kj_data(kj_data[1]), .kj_valid(kj_valid[1]), .kj_ready(kj_ready[1])
`ifdef KJ_CALCULATOR_LAST_EN
        , .kj_last(kj_last[1])
`endif
    );

    kj_calculator u_dut2 (
        .clk(clk), .rst(rst),
        .ehat_data(ehat_data[2]), .ehat_valid(ehat_valid[2]), .ehat_ready(ehat_ready[2]),
        .kj_data(kj_data[2]), .kj_valid(kj_valid[2]), .kj_ready(kj_ready[2])
`ifdef KJ_CALCULATOR_LAST_EN
        , .kj_last(kj_last[2])
`endif
    );

    // Reference model state per instance: plain integer accumulator/count, pending kj queue.
    longint m_acc [3];
    longint m_cnt [3];
    int     m_idx [3];
    int     exp_q [3][$];

    typedef struct {
        int inst;
        bit rst;
        bit ev;
        int e;
        bit kr;
        bit er;
        bit kv;
        bit kd_chk;
        int kd;
        bit last;
    } vec_t;

    vec_t vecs[$];

    function automatic int bsl_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 8;
    endfunction

    function automatic int rl_of(input int i);
        return (i == 2) ? 6 : 2;
    endfunction

    function automatic int ref_kj(input longint acc, input longint cnt);
        for (int k = 0; k < 32; k++) begin
            if (cnt * (longint'(1) << k) >= acc) return k;
        end
        return 31;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input int inst, input bit r, input bit ev, input int e, input bit kr,
                       input bit er, input bit kv, input bit kd_chk, input int kd, input bit last);
        vec_t v;
        v.inst = inst; v.rst = r; v.ev = ev; v.e = e; v.kr = kr;
        v.er = er; v.kv = kv; v.kd_chk = kd_chk; v.kd = kd; v.last = last;
        vecs.push_back(v);
    endtask

    // Called once per cycle at the falling edge, ahead of the rising edge it predicts.
    task automatic sb_tick();
        for (int i = 0; i < 3; i++) begin
            bit     pend;
            bit     er_exp;
            int     n;
            longint e;
            pend   = (exp_q[i].size() != 0);
            er_exp = !rst && (!pend || kj_ready[i]);
            chk($sformatf("sb%0d ehat_ready", i), longint'(ehat_ready[i]), longint'(er_exp));
            chk($sformatf("sb%0d kj_valid", i), longint'(kj_valid[i]), longint'(pend));
            if (pend) begin
                chk($sformatf("sb%0d kj_data", i), longint'(kj_data[i]), longint'(exp_q[i][0] & 31));
`ifdef KJ_CALCULATOR_LAST_EN
                chk($sformatf("sb%0d kj_last", i), longint'(kj_last[i]), longint'((exp_q[i][0] >> 8) & 1));
`endif
                if (kj_ready[i] && !rst) void'(exp_q[i].pop_front());
            end
            if (rst) begin
                exp_q[i].delete();
                m_idx[i] = 0;
                m_acc[i] = 0;
                m_cnt[i] = 0;
            end else if (ehat_valid[i] && er_exp) begin
                n = 1 << bsl_of(i);
                e = longint'(ehat_data[i]);
                if (m_idx[i] == 0) begin
                    m_acc[i] = e;
                    m_cnt[i] = 1;
                end else begin
                    exp_q[i].push_back(ref_kj(m_acc[i], m_cnt[i]) | ((m_idx[i] == n - 1) ? 256 : 0));
                    m_acc[i] = m_acc[i] + e;
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == (longint'(1) << rl_of(i))) begin
                        m_acc[i] = m_acc[i] / 2;
                        m_cnt[i] = m_cnt[i] / 2;
                    end
                end
                m_idx[i] = (m_idx[i] + 1) % n;
            end
        end
    endtask

    initial begin
        // 8,8,8,8 on N=4: kj 3,3,3 and nothing for the block start
        add(0,0,1,8,1, 1,0,1,0,0);
        add(0,0,1,8,1, 1,0,0,0,0);
        add(0,0,1,8,1, 1,1,1,3,0);
        add(0,0,1,8,1, 1,1,1,3,0);
        add(0,0,0,0,1, 1,1,1,3,1);
        add(0,0,0,0,1, 1,0,0,0,0);
        // backpressure: samples 1,3,0,0 with kj_ready low for 5 cycles
        add(0,0,1,1,1, 1,0,0,0,0);
        add(0,0,1,3,0, 1,0,0,0,0);
        for (int j = 0; j < 4; j++) add(0,0,1,0,0, 0,1,1,0,0);
        add(0,0,1,0,1, 1,1,1,0,0);
        add(0,0,1,0,1, 1,1,1,1,0);
        add(0,0,0,0,1, 1,1,1,1,1);
        add(0,0,0,0,1, 1,0,0,0,0);
        // two all-zero blocks: six kj of 0
        add(0,0,1,0,1, 1,0,0,0,0);
        add(0,0,1,0,1, 1,0,0,0,0);
        add(0,0,1,0,1, 1,1,1,0,0);
        add(0,0,1,0,1, 1,1,1,0,0);
        add(0,0,1,0,1, 1,1,1,0,1);
        add(0,0,1,0,1, 1,0,0,0,0);
        add(0,0,1,0,1, 1,1,1,0,0);
        add(0,0,1,0,1, 1,1,1,0,0);
        add(0,0,0,0,1, 1,1,1,0,1);
        add(0,0,0,0,1, 1,0,0,0,0);
        // N=8, rescale at 4: 4,4,4,5,4,4,4,4 -> seven kj of 2
        add(1,0,1,4,1, 1,0,0,0,0);
        add(1,0,1,4,1, 1,0,0,0,0);
        add(1,0,1,4,1, 1,1,1,2,0);
        add(1,0,1,5,1, 1,1,1,2,0);
        for (int j = 0; j < 4; j++) add(1,0,1,4,1, 1,1,1,2,0);
        add(1,0,0,0,1, 1,1,1,2,1);
        add(1,0,0,0,1, 1,0,0,0,0);
        // default params: max error then 0 -> kj 19
        add(2,0,1,524287,1, 1,0,1,0,0);
        add(2,0,1,0,1,      1,0,0,0,0);
        add(2,0,0,0,1,      1,1,1,19,0);
        add(2,0,0,0,1,      1,0,0,0,0);
        // reset after two samples, then a fresh 8,8,8,8 block
        add(0,0,1,8,1,   1,0,0,0,0);
        add(0,0,1,100,0, 1,0,0,0,0);
        add(0,1,1,8,0,   0,1,1,3,0);
        add(0,0,1,8,1,   1,0,1,0,0);
        add(0,0,1,8,1,   1,0,0,0,0);
        add(0,0,1,8,1,   1,1,1,3,0);
        add(0,0,1,8,1,   1,1,1,3,0);
        add(0,0,0,0,1,   1,1,1,3,1);
        add(0,0,0,0,1,   1,0,0,0,0);

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ehat_valid[i] = 1'b0;
            ehat_data[i]  = '0;
            kj_ready[i]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int j = 0; j < vecs.size(); j++) begin
            vec_t v;
            v = vecs[j];
            for (int i = 0; i < 3; i++) begin
                ehat_valid[i] = 1'b0;
                kj_ready[i]   = 1'b1;
            end
            rst = v.rst;
            ehat_valid[v.inst] = v.ev;
            ehat_data[v.inst]  = 19'(v.e);
            kj_ready[v.inst]   = v.kr;
            @(negedge clk);
            chk($sformatf("vec%0d ehat_ready", j), longint'(ehat_ready[v.inst]), longint'(v.er));
            chk($sformatf("vec%0d kj_valid", j), longint'(kj_valid[v.inst]), longint'(v.kv));
            if (v.kd_chk) begin
                chk($sformatf("vec%0d kj_data", j), longint'(kj_data[v.inst]), longint'(v.kd));
`ifdef KJ_CALCULATOR_LAST_EN
                chk($sformatf("vec%0d kj_last", j), longint'(kj_last[v.inst]), longint'(v.last));
`endif
            end
            sb_tick();
            @(posedge clk);
            #1;
        end

        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                int sel;
                sel = int'($urandom_range(0, 3));
                ehat_valid[i] = ($urandom_range(0, 3) != 0);
                kj_ready[i]   = ($urandom_range(0, 9) < 7);
                case (sel)
                    0:       ehat_data[i] = '0;
                    1:       ehat_data[i] = 19'($urandom_range(0, 15));
                    2:       ehat_data[i] = 19'($urandom_range(0, 1023));
                    default: ehat_data[i] = 19'($urandom_range(0, 524287));
                endcase
            end
            @(negedge clk);
            sb_tick();
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 3; i++) begin
            ehat_valid[i] = 1'b0;
            kj_ready[i]   = 1'b1;
        end
        repeat (4) begin
            @(negedge clk);
            sb_tick();
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
